// File: rtl/qupls4_pkg.sv
// Shared types and default widths for the Qupls4 rename backout path.
package qupls4_pkg;

    localparam int unsigned DEF_HIST_DEPTH = 16;
    localparam int unsigned DEF_AREG_W     = 7;
    localparam int unsigned DEF_PREG_W     = 9;
    localparam int unsigned DEF_ROB_W      = 8;

    typedef struct packed {
        logic [DEF_AREG_W-1:0] areg;
        logic [DEF_PREG_W-1:0] old_preg;
        logic [DEF_PREG_W-1:0] new_preg;
        logic [DEF_ROB_W-1:0]  rob;
    } hist_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } backout_state_t;

endpackage

// File: rtl/qupls4_map_history_fifo.sv
// Circular rename-history buffer: push at tail, pop oldest at head, pop youngest at tail.
module qupls4_map_history_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_head,
    input  logic             pop_tail,
    output logic [WIDTH-1:0] tail_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;
    logic [CNT_W-1:0] count_nxt;

    // Callers never push while full nor pop while empty; head and tail pops
    // on the final entry are made exclusive upstream.
    always_comb begin
        tail_last = tail - PTR_W'(1);
        tail_data = mem[tail_last];
        count_nxt = count + CNT_W'(push) - CNT_W'(pop_head) - CNT_W'(pop_tail);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (pop_head) begin
                head <= head + PTR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end else if (pop_tail) begin
                tail <= tail_last;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/qupls4_backout_sequencer.sv
// Undoes younger rename mappings after a branch backout, youngest first, one per cycle,
// restoring the RAT and returning speculative pregs to the free list.
module qupls4_backout_sequencer #(
    parameter int unsigned HIST_DEPTH = qupls4_pkg::DEF_HIST_DEPTH,
    parameter int unsigned AREG_W     = qupls4_pkg::DEF_AREG_W,
    parameter int unsigned PREG_W     = qupls4_pkg::DEF_PREG_W,
    parameter int unsigned ROB_W      = qupls4_pkg::DEF_ROB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hist_wr,
    input  logic [AREG_W-1:0] hist_areg,
    input  logic [PREG_W-1:0] hist_old_preg,
    input  logic [PREG_W-1:0] hist_new_preg,
    input  logic [ROB_W-1:0]  hist_rob,
    input  logic              cmt_v,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              backout,
    input  logic [ROB_W-1:0]  backout_rob,
    output logic              busy,
    output logic              full,
    output logic              ovf,
    output logic              rat_wr,
    output logic [AREG_W-1:0] rat_areg,
    output logic [PREG_W-1:0] rat_preg,
    output logic              fl_free,
    output logic [PREG_W-1:0] fl_preg,
    output logic              done
);
    import qupls4_pkg::*;

    localparam int unsigned ENTRY_W = AREG_W + 2 * PREG_W + ROB_W;
    localparam int unsigned CNT_W   = $clog2(HIST_DEPTH) + 1;

    backout_state_t     state;
    logic [ROB_W-1:0]   bo_rob;
    logic [ENTRY_W-1:0] tail_data;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop_head;
    logic               pop_tail;
    logic [AREG_W-1:0]  ent_areg;
    logic [PREG_W-1:0]  ent_old;
    logic [PREG_W-1:0]  ent_new;
    logic [ROB_W-1:0]   ent_rob;
    logic [ROB_W-1:0]   age_ent;
    logic [ROB_W-1:0]   age_bo;
    logic               younger;

    qupls4_map_history_fifo #(
        .DEPTH (HIST_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({hist_areg, hist_old_preg, hist_new_preg, hist_rob}),
        .pop_head  (pop_head),
        .pop_tail  (pop_tail),
        .tail_data (tail_data),
        .count     (count),
        .full      (full)
    );

    // Age is measured from the ROB head so ROB-id wraparound compares correctly.
    always_comb begin
        ent_rob  = tail_data[ROB_W-1:0];
        ent_new  = tail_data[ROB_W +: PREG_W];
        ent_old  = tail_data[ROB_W+PREG_W +: PREG_W];
        ent_areg = tail_data[ROB_W+2*PREG_W +: AREG_W];
        age_ent  = ent_rob - rob_head;
        age_bo   = bo_rob - rob_head;
        younger  = age_ent > age_bo;
        push     = hist_wr && (state == IDLE) && !backout && !full;
        pop_head = cmt_v && (count != '0);
        // Commit owns the last remaining entry when both want it.
        pop_tail = (state == WALK) && (count != '0) && younger
                   && !(pop_head && (count == CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bo_rob   <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            rat_wr   <= 1'b0;
            rat_areg <= '0;
            rat_preg <= '0;
            fl_free  <= 1'b0;
            fl_preg  <= '0;
            done     <= 1'b0;
        end else begin
            rat_wr  <= 1'b0;
            fl_free <= 1'b0;
            done    <= 1'b0;
            if (hist_wr && (state == IDLE) && full) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (backout) begin
                        bo_rob <= backout_rob;
                        busy   <= 1'b1;
                        state  <= WALK;
                    end
                end
                WALK: begin
                    if (pop_tail) begin
                        rat_wr   <= 1'b1;
                        rat_areg <= ent_areg;
                        rat_preg <= ent_old;
                        fl_free  <= 1'b1;
                        fl_preg  <= ent_new;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qupls4_backout_sequencer.sv
// Directed self-checking bench for qupls4_backout_sequencer.
module tb_qupls4_backout_sequencer;

    logic       clk;
    logic       rst;
    logic       hist_wr;
    logic [6:0] hist_areg;
    logic [8:0] hist_old_preg;
    logic [8:0] hist_new_preg;
    logic [7:0] hist_rob;
    logic       cmt_v;
    logic [7:0] rob_head;
    logic       backout;
    logic [7:0] backout_rob;
    logic       busy;
    logic       full;
    logic       ovf;
    logic       rat_wr;
    logic [6:0] rat_areg;
    logic [8:0] rat_preg;
    logic       fl_free;
    logic [8:0] fl_preg;
    logic       done;

    int errors = 0;
    int checks = 0;

    qupls4_backout_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .hist_wr       (hist_wr),
        .hist_areg     (hist_areg),
        .hist_old_preg (hist_old_preg),
        .hist_new_preg (hist_new_preg),
        .hist_rob      (hist_rob),
        .cmt_v         (cmt_v),
        .rob_head      (rob_head),
        .backout       (backout),
        .backout_rob   (backout_rob),
        .busy          (busy),
        .full          (full),
        .ovf           (ovf),
        .rat_wr        (rat_wr),
        .rat_areg      (rat_areg),
        .rat_preg      (rat_preg),
        .fl_free       (fl_free),
        .fl_preg       (fl_preg),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hist_wr = 1'b0; cmt_v = 1'b0; backout = 1'b0;
        hist_areg = '0; hist_old_preg = '0; hist_new_preg = '0; hist_rob = '0;
        rob_head = '0; backout_rob = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [6:0] a, input logic [8:0] o, input logic [8:0] n, input logic [7:0] r);
        hist_wr = 1'b1; hist_areg = a; hist_old_preg = o; hist_new_preg = n; hist_rob = r;
        tick();
        hist_wr = 1'b0;
    endtask

    task automatic fire_backout(input logic [7:0] r);
        backout = 1'b1; backout_rob = r;
        tick();
        backout = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({busy, full, ovf, rat_wr, fl_free, done} !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b exp 000000", {busy, full, ovf, rat_wr, fl_free, done}); end
        checks++; if (dut.u_hist.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", dut.u_hist.count); end
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        for (int i = 1; i <= 4; i++) push(7'(i), 9'(i + 100), 9'(i + 200), 8'(i));
        fire_backout(8'd0);
        tick();
        checks++; if (rat_wr !== 1'b1 || rat_preg !== 9'd104) begin errors++; $display("FAIL midwalk_first: got wr=%b preg=%0d exp wr=1 preg=104", rat_wr, rat_preg); end
        tick();
        checks++; if (rat_wr !== 1'b1 || rat_preg !== 9'd103) begin errors++; $display("FAIL midwalk_second: got wr=%b preg=%0d exp wr=1 preg=103", rat_wr, rat_preg); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || rat_wr !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL midwalk_rst: got busy=%b wr=%b ovf=%b exp 0 0 0", busy, rat_wr, ovf); end
        checks++; if (dut.u_hist.count !== 5'd0) begin errors++; $display("FAIL midwalk_count: got %0d exp 0", dut.u_hist.count); end
        rst = 1'b0;
        tick();
        checks++; if (rat_wr !== 1'b0 || fl_free !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midwalk_after: got wr=%b free=%b done=%b exp 0 0 0", rat_wr, fl_free, done); end
    endtask

    task automatic test_basic_walk();
        do_reset();
        push(7'd3, 9'd10, 9'd40, 8'd1);
        push(7'd5, 9'd11, 9'd41, 8'd2);
        push(7'd3, 9'd40, 9'd42, 8'd3);
        fire_backout(8'd1);
        checks++; if (busy !== 1'b1 || rat_wr !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b wr=%b exp 1 0", busy, rat_wr); end
        tick();
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_free, fl_preg} !== {1'b1, 7'd3, 9'd40, 1'b1, 9'd42}) begin errors++; $display("FAIL basic_step1: got wr=%b a=%0d p=%0d fr=%b fp=%0d exp 1 3 40 1 42", rat_wr, rat_areg, rat_preg, fl_free, fl_preg); end
        tick();
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_free, fl_preg} !== {1'b1, 7'd5, 9'd11, 1'b1, 9'd41}) begin errors++; $display("FAIL basic_step2: got wr=%b a=%0d p=%0d fr=%b fp=%0d exp 1 5 11 1 41", rat_wr, rat_areg, rat_preg, fl_free, fl_preg); end
        tick();
        checks++; if (done !== 1'b1 || rat_wr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_done: got done=%b wr=%b busy=%b exp 1 0 1", done, rat_wr, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got done=%b busy=%b exp 0 0", done, busy); end
        checks++; if (dut.u_hist.count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d exp 1", dut.u_hist.count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 14; i++) push(7'd0, 9'd0, 9'd0, 8'd0);
        cmt_v = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        cmt_v = 1'b0;
        rob_head = 8'd5;
        push(7'd1, 9'd20, 9'd50, 8'd5);
        push(7'd2, 9'd21, 9'd51, 8'd6);
        push(7'd3, 9'd22, 9'd52, 8'd7);
        push(7'd4, 9'd23, 9'd53, 8'd8);
        checks++; if (dut.u_hist.tail !== 4'd2) begin errors++; $display("FAIL wrap_tail_pre: got %0d exp 2", dut.u_hist.tail); end
        fire_backout(8'd6);
        tick();
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_preg} !== {1'b1, 7'd4, 9'd23, 9'd53}) begin errors++; $display("FAIL wrap_step1: got wr=%b a=%0d p=%0d fp=%0d exp 1 4 23 53", rat_wr, rat_areg, rat_preg, fl_preg); end
        tick();
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_preg} !== {1'b1, 7'd3, 9'd22, 9'd52}) begin errors++; $display("FAIL wrap_step2: got wr=%b a=%0d p=%0d fp=%0d exp 1 3 22 52", rat_wr, rat_areg, rat_preg, fl_preg); end
        tick();
        checks++; if (done !== 1'b1 || rat_wr !== 1'b0) begin errors++; $display("FAIL wrap_done: got done=%b wr=%b exp 1 0", done, rat_wr); end
        checks++; if (dut.u_hist.tail !== 4'd0 || dut.u_hist.count !== 5'd2) begin errors++; $display("FAIL wrap_ptr: got tail=%0d count=%0d exp 0 2", dut.u_hist.tail, dut.u_hist.count); end
        tick();
    endtask

    task automatic test_age_wrap();
        do_reset();
        rob_head = 8'd250;
        push(7'd10, 9'd30, 9'd60, 8'd252);
        push(7'd11, 9'd31, 9'd61, 8'd255);
        push(7'd12, 9'd32, 9'd62, 8'd2);
        fire_backout(8'd254);
        hist_wr = 1'b1;
        tick();
        hist_wr = 1'b0;
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_preg} !== {1'b1, 7'd12, 9'd32, 9'd62}) begin errors++; $display("FAIL agewrap_step1: got wr=%b a=%0d p=%0d fp=%0d exp 1 12 32 62", rat_wr, rat_areg, rat_preg, fl_preg); end
        tick();
        checks++; if ({rat_wr, rat_areg, rat_preg, fl_preg} !== {1'b1, 7'd11, 9'd31, 9'd61}) begin errors++; $display("FAIL agewrap_step2: got wr=%b a=%0d p=%0d fp=%0d exp 1 11 31 61", rat_wr, rat_areg, rat_preg, fl_preg); end
        tick();
        checks++; if (done !== 1'b1 || rat_wr !== 1'b0) begin errors++; $display("FAIL agewrap_done: got done=%b wr=%b exp 1 0", done, rat_wr); end
        checks++; if (dut.u_hist.count !== 5'd1 || ovf !== 1'b0) begin errors++; $display("FAIL agewrap_count: got count=%0d ovf=%b exp 1 0", dut.u_hist.count, ovf); end
        tick();
    endtask

    task automatic test_full_ovf();
        do_reset();
        for (int i = 0; i < 16; i++) push(7'(i), 9'(i), 9'(i), 8'(i));
        checks++; if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL full_16: got full=%b ovf=%b exp 1 0", full, ovf); end
        push(7'd99, 9'd99, 9'd99, 8'd99);
        checks++; if (full !== 1'b1 || ovf !== 1'b1 || dut.u_hist.count !== 5'd16) begin errors++; $display("FAIL full_17: got full=%b ovf=%b count=%0d exp 1 1 16", full, ovf, dut.u_hist.count); end
        cmt_v = 1'b1;
        tick();
        cmt_v = 1'b0;
        checks++; if (full !== 1'b0 || ovf !== 1'b1 || dut.u_hist.count !== 5'd15) begin errors++; $display("FAIL full_commit: got full=%b ovf=%b count=%0d exp 0 1 15", full, ovf, dut.u_hist.count); end
    endtask

    task automatic test_commit_race();
        do_reset();
        push(7'd7, 9'd33, 9'd63, 8'd5);
        fire_backout(8'd2);
        cmt_v = 1'b1;
        tick();
        cmt_v = 1'b0;
        checks++; if (rat_wr !== 1'b0 || fl_free !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL race_done: got wr=%b free=%b done=%b exp 0 0 1", rat_wr, fl_free, done); end
        checks++; if (dut.u_hist.count !== 5'd0) begin errors++; $display("FAIL race_count: got %0d exp 0", dut.u_hist.count); end
        tick();
        checks++; if (rat_wr !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL race_idle: got wr=%b done=%b busy=%b exp 0 0 0", rat_wr, done, busy); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_walk();
        test_basic_walk();
        test_wrap();
        test_age_wrap();
        test_full_ovf();
        test_commit_race();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
